// File: rtl/CDB_types.sv
// Shared types for the fetch stage: the packet pushed into the
// instruction queue, the fetch FSM states and the packet width.
package CDB_types;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_pkt_t;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DRAIN
    } fetch_state_t;

    localparam int FETCH_PKT_WIDTH = 64;

    // Fetch addresses are always word aligned; the low two bits are dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// In-order fetch stage feeding the instruction queue.
// Keeps one request outstanding to instruction memory, pairs each returned
// instruction with its PC and enqueues it, parking it in a holding register
// while the queue is full. A flush redirects the PC; if a request is still
// in flight it is drained and its data thrown away.
// Optional build macro FETCH_PERF_CNT_EN adds perf_fetched / perf_stall
// event counters as extra outputs.
module fetch_unit
    import CDB_types::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h1eceb000,
    parameter int          FIFO_DWIDTH = FETCH_PKT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [31:0]            flush_pc,
    output logic [31:0]            imem_addr,
    output logic [3:0]             imem_rmask,
    input  logic [31:0]            imem_rdata,
    input  logic                   imem_resp,
    input  logic                   iq_full,
    output logic                   iq_enq,
`ifdef FETCH_PERF_CNT_EN
    output logic [FIFO_DWIDTH-1:0] iq_din,
    output logic [31:0]            perf_fetched,
    output logic [31:0]            perf_stall
`else
    output logic [FIFO_DWIDTH-1:0] iq_din
`endif
);

    generate
        if (FIFO_DWIDTH != FETCH_PKT_WIDTH) begin : g_width_check
            $error("fetch_unit: FIFO_DWIDTH must equal FETCH_PKT_WIDTH");
        end
    endgenerate

    fetch_state_t state, state_next;
    logic [31:0]  pc, pc_next;
    logic [31:0]  redirect_pc, redirect_next;
    logic [31:0]  held_inst, held_next;
    fetch_pkt_t   pkt;

    // State, PC, pending redirect target and parked instruction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            redirect_pc <= RESET_PC;
            held_inst   <= 32'h0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            redirect_pc <= redirect_next;
            held_inst   <= held_next;
        end
    end

    // Next-state and outputs; all outputs are forced quiet while reset is held.
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        redirect_next = redirect_pc;
        held_next     = held_inst;
        iq_enq        = 1'b0;
        pkt           = '0;
        imem_rmask    = 4'h0;
        imem_addr     = pc;

        case (state)
            FETCH: begin
                imem_rmask = 4'hf;
                if (flush) begin
                    if (imem_resp) begin
                        pc_next = align_word(flush_pc);
                    end else begin
                        state_next    = DRAIN;
                        redirect_next = align_word(flush_pc);
                    end
                end else if (imem_resp) begin
                    if (!iq_full) begin
                        iq_enq   = 1'b1;
                        pkt.pc   = pc;
                        pkt.inst = imem_rdata;
                        pc_next  = pc + 32'd4;
                    end else begin
                        held_next  = imem_rdata;
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (flush) begin
                    state_next = FETCH;
                    pc_next    = align_word(flush_pc);
                end else if (!iq_full) begin
                    iq_enq     = 1'b1;
                    pkt.pc     = pc;
                    pkt.inst   = held_inst;
                    pc_next    = pc + 32'd4;
                    state_next = FETCH;
                end
            end
            DRAIN: begin
                imem_rmask = 4'hf;
                if (imem_resp) begin
                    state_next = FETCH;
                    pc_next    = flush ? align_word(flush_pc) : redirect_pc;
                end else if (flush) begin
                    redirect_next = align_word(flush_pc);
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase

        if (!rst) begin
            imem_rmask = 4'h0;
            iq_enq     = 1'b0;
            pkt        = '0;
        end
    end

    assign iq_din = FIFO_DWIDTH'(pkt);

`ifdef FETCH_PERF_CNT_EN
    logic stall_evt;
    assign stall_evt = (state == HOLD) || ((state == FETCH) && imem_resp && iq_full);

    // Free-running event counters; only reset clears them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched <= 32'h0;
            perf_stall   <= 32'h0;
        end else begin
            if (iq_enq) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (stall_evt) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with hand-computed expectations.
// Inputs change 1ns after the rising edge; outputs are checked on the
// falling edge of the same cycle.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [31:0] flush_pc;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        iq_full;
    logic        iq_enq;
    logic [63:0] iq_din;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    int tests_run;
    int tests_failed;

    fetch_unit #(
        .RESET_PC    (32'h1eceb000),
        .FIFO_DWIDTH (64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .imem_addr  (imem_addr),
        .imem_rmask (imem_rmask),
        .imem_rdata (imem_rdata),
        .imem_resp  (imem_resp),
        .iq_full    (iq_full),
        .iq_enq     (iq_enq),
`ifdef FETCH_PERF_CNT_EN
        .iq_din       (iq_din),
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall)
`else
        .iq_din     (iq_din)
`endif
    );

    // Free-running clock, period 10ns.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge, then wait for the falling edge.
    task automatic applyStimulus(input logic fl, input logic [31:0] fpc, input logic resp,
                                 input logic [31:0] rdata, input logic full);
        @(posedge clk);
        #1;
        flush      = fl;
        flush_pc   = fpc;
        imem_resp  = resp;
        imem_rdata = rdata;
        iq_full    = full;
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    // Assert reset away from a clock edge, check quiet outputs, release mid-cycle.
    task automatic resetDut();
        rst        = 1'b0;
        flush      = 1'b0;
        flush_pc   = 32'h0;
        imem_resp  = 1'b0;
        imem_rdata = 32'h0;
        iq_full    = 1'b0;
        #1;
        checkOutput("rst_rmask", 64'(imem_rmask), 64'h0);
        checkOutput("rst_enq", 64'(iq_enq), 64'h0);
        checkOutput("rst_din", iq_din, 64'h0);
`ifdef FETCH_PERF_CNT_EN
        checkOutput("rst_perf_fetched", 64'(perf_fetched), 64'h0);
        checkOutput("rst_perf_stall", 64'(perf_stall), 64'h0);
`endif
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("post_rst_rmask", 64'(imem_rmask), 64'hf);
        checkOutput("post_rst_addr", 64'(imem_addr), 64'h1eceb000);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        // 1: single-cycle memory streaming three instructions
        resetDut();
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h00000013, 1'b0);
        checkOutput("t1_addr0", 64'(imem_addr), 64'h1eceb000);
        checkOutput("t1_enq0", 64'(iq_enq), 64'h1);
        checkOutput("t1_din0", iq_din, 64'h1eceb000_00000013);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h00100093, 1'b0);
        checkOutput("t1_addr1", 64'(imem_addr), 64'h1eceb004);
        checkOutput("t1_din1", iq_din, 64'h1eceb004_00100093);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h00200113, 1'b0);
        checkOutput("t1_addr2", 64'(imem_addr), 64'h1eceb008);
        checkOutput("t1_din2", iq_din, 64'h1eceb008_00200113);

        // 2: queue full on response parks the instruction in HOLD
        resetDut();
        applyStimulus(1'b0, 32'h0, 1'b1, 32'hdeadbeef, 1'b1);
        checkOutput("t2_full_enq", 64'(iq_enq), 64'h0);
        checkOutput("t2_full_din", iq_din, 64'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checkOutput("t2_hold_rmask", 64'(imem_rmask), 64'h0);
        checkOutput("t2_hold_enq", 64'(iq_enq), 64'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checkOutput("t2_hold2_enq", 64'(iq_enq), 64'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("t2_release_enq", 64'(iq_enq), 64'h1);
        checkOutput("t2_release_din", iq_din, 64'h1eceb000_deadbeef);
        idle();
        checkOutput("t2_next_addr", 64'(imem_addr), 64'h1eceb004);
        checkOutput("t2_next_rmask", 64'(imem_rmask), 64'hf);

        // 3: flush while a slow request is pending drains it
        idle();
        applyStimulus(1'b1, 32'h00001002, 1'b0, 32'h0, 1'b0);
        checkOutput("t3_flush_enq", 64'(iq_enq), 64'h0);
        idle();
        checkOutput("t3_drain_addr", 64'(imem_addr), 64'h1eceb004);
        checkOutput("t3_drain_rmask", 64'(imem_rmask), 64'hf);
        idle();
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h12345678, 1'b0);
        checkOutput("t3_stale_enq", 64'(iq_enq), 64'h0);
        checkOutput("t3_stale_din", iq_din, 64'h0);
        idle();
        checkOutput("t3_redirect_addr", 64'(imem_addr), 64'h00001000);

        // 4: latest flush during DRAIN wins
        applyStimulus(1'b1, 32'h00000100, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 32'h00000200, 1'b0, 32'h0, 1'b0);
        checkOutput("t4_drain_addr", 64'(imem_addr), 64'h00001000);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'hcafef00d, 1'b0);
        checkOutput("t4_stale_enq", 64'(iq_enq), 64'h0);
        idle();
        checkOutput("t4_redirect_addr", 64'(imem_addr), 64'h00000200);

        // 5: flush coinciding with a response
        applyStimulus(1'b1, 32'h00000400, 1'b1, 32'haaaa5555, 1'b0);
        checkOutput("t5_enq", 64'(iq_enq), 64'h0);
        idle();
        checkOutput("t5_addr", 64'(imem_addr), 64'h00000400);

        // PC wrap and flush target alignment
        applyStimulus(1'b1, 32'hfffffffe, 1'b1, 32'h0, 1'b0);
        idle();
        checkOutput("wrap_aligned_addr", 64'(imem_addr), 64'hfffffffc);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h00000011, 1'b0);
        checkOutput("wrap_din", iq_din, 64'hfffffffc_00000011);
        idle();
        checkOutput("wrap_addr", 64'(imem_addr), 64'h00000000);

        // Flush in HOLD drops the parked instruction even with room in the queue
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h0badf00d, 1'b1);
        applyStimulus(1'b1, 32'h00000500, 1'b0, 32'h0, 1'b0);
        checkOutput("hold_flush_enq", 64'(iq_enq), 64'h0);
        idle();
        checkOutput("hold_flush_addr", 64'(imem_addr), 64'h00000500);

        // 6: reset in the middle of a request
        resetDut();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 32'h00000013, 1'b0);
        end
        idle();
        checkOutput("t6_addr", 64'(imem_addr), 64'h1eceb010);
`ifdef FETCH_PERF_CNT_EN
        checkOutput("t6_perf_fetched", 64'(perf_fetched), 64'h4);
`endif
        resetDut();
        idle();
        checkOutput("t6_restart_addr", 64'(imem_addr), 64'h1eceb000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
In-order instruction fetch stage that sits directly upstream of the instruction-queue FIFO.
- Holds the PC and issues one 32-bit read at a time to the instruction memory/cache port.
- Packs each returned instruction with its PC and enqueues it into the queue, respecting the queue's full flag.
- Redirects to a new PC on flush and discards any in-flight response.

Parameters:
RESET_PC, 32'h1eceb000, PC fetched first after reset.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous, active-low reset.
flush  in  1  redirect request from backend; also drives the queue's flush.
flush_pc  in  32  redirect target; bits [1:0] ignored and forced to 0.
imem_addr  out  32  fetch address; word aligned; stable while a request is pending.
imem_rmask  out  4  4'hf while a request is pending, else 4'h0.
imem_rdata  in  32  instruction returned by memory.
imem_resp  in  1  one-cycle completion of the pending request.
iq_full  in  1  full flag from the instruction queue.
iq_enq  out  1  enqueue strobe to the queue.
iq_din  out  FIFO_DWIDTH  packet {pc[31:0], inst[31:0]} (pc in upper half).

Behaviour:
- Reset (rst=0, asynchronous):
  - state=FETCH, pc=RESET_PC, redirect_pc=RESET_PC, held_inst=0.
  - Outputs while in reset: imem_rmask=0, iq_enq=0, iq_din=0.
  - First cycle after rst rises: imem_rmask=4'hf, imem_addr=RESET_PC.
- Single outstanding request. imem_addr and imem_rmask are held constant from issue until imem_resp.
- FETCH (request pending; imem_rmask=4'hf, imem_addr=pc):
  - flush: resp=1 → FETCH with pc=flush_pc, no enq. resp=0 → DRAIN with redirect_pc=flush_pc.
  - resp=1, !iq_full → iq_enq=1 in the same cycle (combinational), iq_din={pc, imem_rdata}, pc<=pc+4, stay FETCH.
  - resp=1, iq_full → held_inst<=imem_rdata, go to HOLD.
  - resp=0 → stay.
- HOLD (no request; imem_rmask=0):
  - flush → FETCH, pc=flush_pc, held instruction dropped.
  - !iq_full → iq_enq=1, iq_din={pc, held_inst}, pc<=pc+4, go to FETCH.
  - Otherwise stay.
- DRAIN (stale request still pending; imem_addr unchanged, rmask=4'hf):
  - flush → redirect_pc<=flush_pc (latest flush wins).
  - resp=1 → data discarded, no enq, FETCH with pc=redirect_pc (or the same-cycle flush_pc).
- iq_enq is never asserted when iq_full=1 or when flush=1.
- iq_din=0 whenever iq_enq=0.
- pc+4 wraps modulo 2^32 (32'hfffffffc → 0).
- Throughput: at most one instruction per cycle; one per cycle only with a single-cycle-response memory.
- Reset mid-request: the pending request is abandoned. Memory must tolerate rmask dropping without resp.

Optional Feature:
Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetched (32) and perf_stall (32).
  - perf_fetched increments on every iq_enq.
  - perf_stall increments each cycle in HOLD, or in FETCH with resp=1 and iq_full=1.
  - Both clear on reset, are not cleared by flush, and wrap.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- CDB_types package:
  - typedef fetch_pkt_t struct {pc, inst};
  - enum fetch_state_t {FETCH, HOLD, DRAIN};
  - localparam FETCH_PKT_WIDTH=64, with a static check that FIFO_DWIDTH == FETCH_PKT_WIDTH.
- No sub-module. Single always_ff for state/pc/redirect_pc/held_inst, plus one always_comb for outputs and next-state.

Test Plan:
1. Reset, 1-cycle memory, iq_full=0 → imem_addr sequence 1eceb000, 1eceb004, 1eceb008. iq_enq each response cycle; iq_din=64'h1eceb000_00000013 for rdata=32'h00000013.
2. iq_full=1 when resp arrives with rdata=32'hdeadbeef → HOLD, rmask=0, no enq. Drop iq_full after 3 cycles → one enq of {1eceb000, deadbeef}, then request 1eceb004.
3. Memory latency 5 cycles; flush with flush_pc=32'h00001002 in cycle 2 → address held until resp, response dropped. Next request at 32'h00001000, no enq in between.
4. Two flushes during DRAIN (pc 0x100 then 0x200) → next fetch at 0x200.
5. Flush coinciding with resp (flush_pc=0x400) → no enq; next cycle imem_addr=0x400.
6. rst pulled low mid-request at pc 0x1eceb010 → rmask=0 immediately; after release, fetch restarts at 1eceb000. With FETCH_PERF_CNT_EN, both counters read 0.
